// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared types and constants for the cache-to-memory arbiter
package cache_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   // ceil(log2(value)), never below 1 so it can size a register
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - requester and memory-side signal bundle of the arbiter
interface cache_mem_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_error;
   logic [DATA_W-1:0]         req_rdata;
   logic [ADDR_W-1:0]         mem_addr_out;
   logic [DATA_W-1:0]         mem_data_out;
   logic                      mem_read_en;
   logic                      mem_write_en;
   logic [DATA_W-1:0]         mem_data_in;
   logic                      mem_ready;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_data_in, mem_ready,
      output req_ready, req_error, req_rdata, mem_addr_out, mem_data_out,
             mem_read_en, mem_write_en
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_data_in, mem_ready,
      input  req_ready, req_error, req_rdata, mem_addr_out, mem_data_out,
             mem_read_en, mem_write_en
   );
endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// rtl/cache_mem_arbiter_rr_arbiter.sv - combinational round-robin picker searching upward from ptr_i
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               any_valid_o
);

   logic [IDX_W:0]   idx_w;
   logic [IDX_W-1:0] idx;

   // Scan from the farthest candidate down so the one nearest ptr_i is written last and wins.
   always_comb begin
      grant_idx_o = '0;
      any_valid_o = |valid_i;
      idx_w       = '0;
      idx         = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_w = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (idx_w >= (IDX_W+1)'(NUM_REQ)) idx_w = idx_w - (IDX_W+1)'(NUM_REQ);
         idx = idx_w[IDX_W-1:0];
         if (valid_i[idx]) grant_idx_o = idx;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin sharing of one memory port with a completion watchdog
module cache_mem_arbiter
   import cache_mem_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              reset,
   cache_mem_arbiter_if.slave bus
);

   localparam int IDX_W = clog2(NUM_REQ);
   localparam int TMR_W = clog2(TIMEOUT);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     id_q, id_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic [NUM_REQ-1:0]   error_q, error_d;
   logic                 rd_en_q, rd_en_d;
   logic                 wr_en_q, wr_en_d;

   logic [IDX_W-1:0]     grant_idx;
   logic                 any_valid;
   logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .valid_i     (bus.req_valid),
      .ptr_i       (rr_ptr_q),
      .grant_idx_o (grant_idx),
      .any_valid_o (any_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         timer_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ready_q  <= '0;
         error_q  <= '0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         timer_q  <= timer_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         error_q  <= error_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      timer_d  = timer_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ready_d  = '0;
      error_d  = '0;
      rd_en_d  = rd_en_q;
      wr_en_d  = wr_en_q;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               id_d    = grant_idx;
               we_d    = bus.req_we[grant_idx];
               addr_d  = addr_arr[grant_idx];
               wdata_d = wdata_arr[grant_idx];
               rd_en_d = ~bus.req_we[grant_idx];
               wr_en_d = bus.req_we[grant_idx];
               timer_d = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            timer_d = timer_q + 1'b1;
            // A completion in the watchdog's last cycle still counts as success.
            if (bus.mem_ready) begin
               rd_en_d        = 1'b0;
               wr_en_d        = 1'b0;
               rdata_d        = we_q ? '0 : bus.mem_data_in;
               ready_d[id_q]  = 1'b1;
               state_d        = ST_DONE;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               rd_en_d        = 1'b0;
               wr_en_d        = 1'b0;
               rdata_d        = '0;
               ready_d[id_q]  = 1'b1;
               error_d[id_q]  = 1'b1;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: begin
            rr_ptr_d = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            timer_d  = '0;
            rdata_d  = '0;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            rd_en_d = 1'b0;
            wr_en_d = 1'b0;
         end
      endcase
   end

   assign bus.req_ready    = ready_q;
   assign bus.req_error    = error_q;
   assign bus.req_rdata    = rdata_q;
   assign bus.mem_addr_out = addr_q;
   assign bus.mem_data_out = wdata_q;
   assign bus.mem_read_en  = rd_en_q;
   assign bus.mem_write_en = wr_en_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed vector bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   cache_mem_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32)) bus ();

   cache_mem_arbiter #(
      .NUM_REQ (2),
      .ADDR_W  (16),
      .DATA_W  (32),
      .TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  we;
      logic        mrdy;
      logic [31:0] mdata;
      logic [1:0]  e_ready;
      logic [1:0]  e_err;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_rdata;
      logic [15:0] e_addr;
      logic [31:0] e_dout;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One requester transaction; mem_ready is raised on strobe cycle ready_at (0 = never).
   task automatic do_txn(input int idx, input logic we, input int ready_at,
                         input logic [31:0] data, output int strobes, output int bad,
                         output logic [1:0] rdy, output logic [1:0] err,
                         output logic [31:0] rd, output logic [1:0] rdy_next,
                         output logic done);
      strobes = 0; bad = 0; rdy = '0; err = '0; rd = '0; rdy_next = '0; done = 1'b0;
      bus.req_valid[idx] = 1'b1;
      bus.req_we[idx]    = we;
      bus.mem_data_in    = data;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) begin
            rdy = bus.req_ready; err = bus.req_error; rd = bus.req_rdata;
            done = 1'b1;
            bus.req_valid = '0;
            bus.mem_ready = 1'b0;
            break;
         end
         if (we ? bus.mem_write_en : bus.mem_read_en) strobes++;
         if (we ? bus.mem_read_en : bus.mem_write_en) bad++;
         bus.mem_ready = (ready_at != 0 && strobes == ready_at);
      end
      @(negedge clk);
      rdy_next = bus.req_ready;
   endtask

   int          t_strobes, t_bad;
   logic [1:0]  t_rdy, t_err, t_rdy_next;
   logic [31:0] t_rd;
   logic        t_done;

   initial begin
      n_cmp = 0; n_fail = 0;
      reset = 1'b0;
      bus.req_valid = '0; bus.req_we = '0;
      bus.req_addr  = {16'h0100, 16'h0040};
      bus.req_wdata = {32'h12345678, 32'h0BADF00D};
      bus.mem_ready = 1'b0; bus.mem_data_in = '0;

      //          valid  we     rdy   mdata          e_ready e_err e_rd e_wr e_rdata        e_addr    e_dout
      vecs[0]  = '{2'b01, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0000, 32'h0};
      vecs[1]  = '{2'b01, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[2]  = '{2'b01, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[3]  = '{2'b01, 2'b00, 1'b1, 32'hDEADBEEF,  2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[4]  = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 1'b0, 32'hDEADBEEF,  16'h0040, 32'h0BADF00D};
      vecs[5]  = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[6]  = '{2'b10, 2'b10, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[7]  = '{2'b10, 2'b10, 1'b1, 32'h55555555,  2'b00, 2'b00, 1'b0, 1'b1, 32'h0,         16'h0100, 32'h12345678};
      vecs[8]  = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0100, 32'h12345678};
      vecs[9]  = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0100, 32'h12345678};
      vecs[10] = '{2'b11, 2'b00, 1'b1, 32'h11110000,  2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0100, 32'h12345678};
      vecs[11] = '{2'b11, 2'b00, 1'b1, 32'h11110001,  2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[12] = '{2'b11, 2'b00, 1'b1, 32'h11110002,  2'b01, 2'b00, 1'b0, 1'b0, 32'h11110001,  16'h0040, 32'h0BADF00D};
      vecs[13] = '{2'b11, 2'b00, 1'b1, 32'h11110003,  2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[14] = '{2'b11, 2'b00, 1'b1, 32'h11110004,  2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0100, 32'h12345678};
      vecs[15] = '{2'b11, 2'b00, 1'b1, 32'h11110005,  2'b10, 2'b00, 1'b0, 1'b0, 32'h11110004,  16'h0100, 32'h12345678};
      vecs[16] = '{2'b11, 2'b00, 1'b1, 32'h11110006,  2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0100, 32'h12345678};
      vecs[17] = '{2'b11, 2'b00, 1'b1, 32'h11110007,  2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[18] = '{2'b11, 2'b00, 1'b1, 32'h11110008,  2'b01, 2'b00, 1'b0, 1'b0, 32'h11110007,  16'h0040, 32'h0BADF00D};
      vecs[19] = '{2'b11, 2'b00, 1'b1, 32'h11110009,  2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0040, 32'h0BADF00D};
      vecs[20] = '{2'b11, 2'b00, 1'b1, 32'h1111000A,  2'b00, 2'b00, 1'b1, 1'b0, 32'h0,         16'h0100, 32'h12345678};
      vecs[21] = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, 1'b0, 32'h1111000A,  16'h0100, 32'h12345678};
      vecs[22] = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         16'h0100, 32'h12345678};

      #3;
      chk("reset ready", 32'(bus.req_ready), 32'h0);
      chk("reset rd_en", 32'(bus.mem_read_en), 32'h0);
      chk("reset wr_en", 32'(bus.mem_write_en), 32'h0);
      chk("reset addr", 32'(bus.mem_addr_out), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Each row: outputs expected this cycle, then inputs held until the next cycle.
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         chk($sformatf("row%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].e_ready));
         chk($sformatf("row%0d error", i), 32'(bus.req_error), 32'(vecs[i].e_err));
         chk($sformatf("row%0d rd_en", i), 32'(bus.mem_read_en), 32'(vecs[i].e_rd));
         chk($sformatf("row%0d wr_en", i), 32'(bus.mem_write_en), 32'(vecs[i].e_wr));
         chk($sformatf("row%0d addr", i), 32'(bus.mem_addr_out), 32'(vecs[i].e_addr));
         chk($sformatf("row%0d dout", i), bus.mem_data_out, vecs[i].e_dout);
         if (vecs[i].e_ready != 2'b00)
            chk($sformatf("row%0d rdata", i), bus.req_rdata, vecs[i].e_rdata);
         bus.req_valid   = vecs[i].valid;
         bus.req_we      = vecs[i].we;
         bus.mem_ready   = vecs[i].mrdy;
         bus.mem_data_in = vecs[i].mdata;
      end

      // Watchdog abort: strobe for exactly TIMEOUT cycles then ready+error.
      do_txn(0, 1'b0, 0, 32'hAAAA5555, t_strobes, t_bad, t_rdy, t_err, t_rd, t_rdy_next, t_done);
      chk("timeout done", 32'(t_done), 32'h1);
      chk("timeout strobes", 32'(t_strobes), 32'd8);
      chk("timeout ready", 32'(t_rdy), 32'h1);
      chk("timeout error", 32'(t_err), 32'h1);
      chk("timeout rdata", t_rd, 32'h0);
      chk("timeout pulse width", 32'(t_rdy_next), 32'h0);

      do_txn(1, 1'b1, 2, 32'h77777777, t_strobes, t_bad, t_rdy, t_err, t_rd, t_rdy_next, t_done);
      chk("after-timeout done", 32'(t_done), 32'h1);
      chk("after-timeout strobes", 32'(t_strobes), 32'd2);
      chk("after-timeout wrong strobe", 32'(t_bad), 32'd0);
      chk("after-timeout ready", 32'(t_rdy), 32'h2);
      chk("after-timeout error", 32'(t_err), 32'h0);
      chk("after-timeout rdata", t_rd, 32'h0);

      // mem_ready coincides with the last watchdog cycle.
      do_txn(0, 1'b0, 8, 32'hC0FFEE01, t_strobes, t_bad, t_rdy, t_err, t_rd, t_rdy_next, t_done);
      chk("race done", 32'(t_done), 32'h1);
      chk("race strobes", 32'(t_strobes), 32'd8);
      chk("race ready", 32'(t_rdy), 32'h1);
      chk("race error", 32'(t_err), 32'h0);
      chk("race rdata", t_rd, 32'hC0FFEE01);

      // Reset two cycles into BUSY; rr pointer is 1 here so requester 1 is granted.
      bus.req_valid = 2'b10; bus.req_we = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset rd_en", 32'(bus.mem_read_en), 32'h1);
      chk("pre-reset addr", 32'(bus.mem_addr_out), 32'h0100);
      #2 reset = 1'b0;
      #1;
      chk("async rd_en drop", 32'(bus.mem_read_en), 32'h0);
      chk("async addr clear", 32'(bus.mem_addr_out), 32'h0);
      bus.req_valid = 2'b11;
      @(negedge clk);
      chk("in-reset ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      chk("in-reset ready 2", 32'(bus.req_ready), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("post-reset rd_en", 32'(bus.mem_read_en), 32'h1);
      chk("post-reset grant addr", 32'(bus.mem_addr_out), 32'h0040);
      bus.mem_ready = 1'b1; bus.mem_data_in = 32'h600DCAFE;
      @(negedge clk);
      chk("post-reset ready", 32'(bus.req_ready), 32'h1);
      chk("post-reset rdata", bus.req_rdata, 32'h600DCAFE);
      bus.req_valid = '0; bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("post-reset pulse width", 32'(bus.req_ready), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cache-to-memory port between NUM_REQ requesters, for example instruction-side and data-side cache miss engines.
- Grants are round-robin, one transaction at a time.
- The block drives the mem_* handshake and holds the strobes until mem_ready.
- A watchdog counter aborts transactions that memory never completes and flags them to the requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 32, data width
- TIMEOUT, 256, max cycles in BUSY before abort (>=2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready pulse
- req_we  in  NUM_REQ  1 = write, 0 = read; stable while valid
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_error  out  NUM_REQ  one-cycle pulse, coincident with req_ready, on timeout abort
- req_rdata  out  DATA_W  read data; valid while any req_ready bit is high
- mem_addr_out  out  ADDR_W  latched address of the current transaction
- mem_data_out  out  DATA_W  latched write data
- mem_read_en  out  1  read strobe, level, held until mem_ready
- mem_write_en  out  1  write strobe, level, held until mem_ready
- mem_data_in  in  DATA_W  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completion, single cycle

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, rr_ptr=0, timer=0. Strobes drop immediately, even mid-transaction. No completion pulse is produced for an interrupted transaction.
- FSM states: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If any req_valid is set, select the winner by searching round-robin from rr_ptr upward with wrap.
  - Latch id, addr, wdata and we.
  - Go to BUSY. mem_read_en = ~we or mem_write_en = we goes high at the next edge.
  - Exactly one strobe is ever high.
- BUSY:
  - Strobes held; timer increments each cycle.
  - mem_ready=1: capture mem_data_in (reads only; writes return 0), drop strobes, go to DONE with req_ready[id]=1.
  - timer==TIMEOUT-1 with mem_ready=0: drop strobes, go to DONE with req_ready[id]=1, req_error[id]=1, rdata=0.
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins and no error is flagged.
- DONE:
  - Ready pulse visible for this cycle only.
  - rr_ptr <= (id+1) mod NUM_REQ; timer cleared; go to IDLE.
  - The requester must drop or renew req_valid at this edge.
- Latency:
  - Request seen in IDLE at cycle T: strobe high from T+1.
  - mem_ready at cycle M (M >= T+1): req_ready at M+1.
  - Next grant decision at M+2, strobe at M+3. Minimum 3-cycle occupancy per transaction.
- Mem outputs: mem_addr_out and mem_data_out are held from the grant until the next grant; they are not cleared in IDLE.
- Fairness: a continuously requesting agent cannot be granted twice in a row while another is valid.
- Request changes: req_valid dropping while BUSY is ignored; the transaction completes.
- Unsolicited mem_ready: ignored in IDLE and DONE.
- Outputs: all are registered, with no combinational path from input to output.

Decomposition:
- Package cache_mem_pkg holds:
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
  - default ADDR_W/DATA_W constants
  - the timer width function clog2(TIMEOUT)
- One sub-module, rr_arbiter: combinational round-robin priority picker, (valid vector, rr_ptr) -> grant index plus any_valid. Reusable elsewhere.

Test Plan:
- Single read: req_valid=01, req_we=0, addr0=0x0040; memory returns 0xDEADBEEF with mem_ready 3 cycles after the strobe -> mem_read_en high for 3 cycles with mem_addr_out=0x0040; req_ready=01 for 1 cycle with req_rdata=0xDEADBEEF; req_error=00.
- Write: requester 1 writes 0x12345678 to 0x0100 -> mem_write_en=1, mem_data_out=0x12345678, mem_addr_out=0x0100; req_ready=10 one cycle after mem_ready; mem_read_en never asserted.
- Contention: both requesters valid continuously, zero-wait memory (mem_ready on first strobe cycle) -> grant order 0,1,0,1; each transaction occupies 3 cycles; no back-to-back grants to the same requester.
- Timeout: TIMEOUT=8, mem_ready held 0 -> strobe high exactly 8 cycles, then req_ready=req_error=1 for one cycle, req_rdata=0; next request is served normally.
- Race: mem_ready asserted in the same cycle the timer reaches TIMEOUT-1 -> req_ready=1, req_error=0, data captured.
- Mid-transaction reset: reset driven low 2 cycles into BUSY -> mem_read_en drops asynchronously, no req_ready pulse; after release the FSM is in IDLE, rr_ptr=0 and requester 0 is granted first.
